// File: rtl/fc_layer_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fc_layer_engine_if                                                         |
// | Start/done handshake plus activation, weight, bias and result RAM ports.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface fc_layer_engine_if #(
  parameter int DW    = 16,
  parameter int LANES = 16,
  parameter int N_IN  = 256,
  parameter int N_OUT = 64
);
  localparam int CHUNKS = N_IN / LANES;
  localparam int AAW    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int WAW    = (N_OUT * CHUNKS > 1) ? $clog2(N_OUT * CHUNKS) : 1;
  localparam int NAW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic                  start;
  logic                  busy;
  logic                  done;
  logic [AAW-1:0]        act_addr;
  logic [LANES*DW-1:0]   act_data;
  logic [WAW-1:0]        w_addr;
  logic [LANES*DW-1:0]   w_data;
  logic [NAW-1:0]        b_addr;
  logic [DW-1:0]         b_data;
  logic                  out_wren;
  logic [NAW-1:0]        out_addr;
  logic [DW-1:0]         out_data;

  // The engine side drives addresses and results.
  modport master (
    input  start, act_data, w_data, b_data,
    output busy, done, act_addr, w_addr, b_addr, out_wren, out_addr, out_data
  );

  modport slave (
    output start, act_data, w_data, b_data,
    input  busy, done, act_addr, w_addr, b_addr, out_wren, out_addr, out_data
  );
endinterface
`default_nettype wire

// File: rtl/fc_layer_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fc_layer_engine                                                            |
// | Self-sequencing dense layer: y[n] = sat((a.w[n] + b[n]<<FRAC) >>> FRAC).   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fc_layer_engine #(
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int LANES = 16,
  parameter int N_IN  = 256,
  parameter int N_OUT = 64,
  parameter int RELU  = 1
) (
  input wire logic          clk,
  input wire logic          rst_n,
  fc_layer_engine_if.master bus
);
  localparam int CHUNKS = N_IN / LANES;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int NW     = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int WAW    = (N_OUT * CHUNKS > 1) ? $clog2(N_OUT * CHUNKS) : 1;
  localparam int AW     = 2 * DW + $clog2(N_IN);
  localparam int RW     = AW + 1;

  localparam logic [CW-1:0]        C_LAST_CHUNK  = CW'(CHUNKS - 1);
  localparam logic [NW-1:0]        C_LAST_NEURON = NW'(N_OUT - 1);
  localparam logic signed [RW-1:0] C_MAX = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [RW-1:0] C_MIN = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_c;
  logic [NW-1:0]         r_n;
  logic [WAW-1:0]        r_w_addr;
  logic                  r_valid;
  logic                  r_first;
  logic signed [AW-1:0]  r_acc;
  logic signed [DW-1:0]  r_bias;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_wren;
  logic [NW-1:0]         r_out_addr;
  logic [DW-1:0]         r_out_data;

  logic signed [2*DW-1:0] w_prod;
  logic signed [AW-1:0]   w_chunk_sum;
  logic signed [AW-1:0]   w_acc_next;
  logic signed [DW-1:0]   w_bias;
  logic signed [RW-1:0]   w_biased;
  logic signed [RW-1:0]   w_shifted;
  logic [DW-1:0]          w_result;

  // The result is formed from the accumulator's next value so that the
  // registered write lands in the cycle right after the last chunk drains.
  always_comb begin
    w_prod      = '0;
    w_chunk_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      w_prod      = $signed(bus.act_data[k*DW +: DW]) * $signed(bus.w_data[k*DW +: DW]);
      w_chunk_sum = w_chunk_sum + AW'(w_prod);
    end
    w_acc_next = r_first ? w_chunk_sum : r_acc + w_chunk_sum;
    // With a single chunk the bias word is still on the bus, not yet in r_bias.
    w_bias     = r_first ? $signed(bus.b_data) : r_bias;
    w_biased   = RW'(w_acc_next) + (RW'(w_bias) <<< FRAC);
    w_shifted  = w_biased >>> FRAC;
    if (w_shifted > C_MAX)
      w_result = C_MAX[DW-1:0];
    else if (w_shifted < C_MIN)
      w_result = C_MIN[DW-1:0];
    else
      w_result = w_shifted[DW-1:0];
    if (RELU != 0 && w_result[DW-1])
      w_result = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_c        <= '0;
      r_n        <= '0;
      r_w_addr   <= '0;
      r_valid    <= 1'b0;
      r_first    <= 1'b0;
      r_acc      <= '0;
      r_bias     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wren     <= 1'b0;
      r_out_addr <= '0;
      r_out_data <= '0;
    end else begin
      r_valid <= (r_state == S_RUN);
      r_first <= (r_state == S_RUN) && (r_c == '0);
      r_wren  <= 1'b0;
      r_done  <= 1'b0;
      if (r_valid) begin
        r_acc <= w_acc_next;
        if (r_first)
          r_bias <= $signed(bus.b_data);
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state  <= S_RUN;
            r_c      <= '0;
            r_n      <= '0;
            r_w_addr <= '0;
            r_busy   <= 1'b1;
          end
        end
        S_RUN: begin
          // Weight rows are contiguous, so the address simply keeps counting.
          r_c      <= r_c + 1'b1;
          r_w_addr <= r_w_addr + 1'b1;
          if (r_c == C_LAST_CHUNK)
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_state    <= S_WRITE;
          r_wren     <= 1'b1;
          r_out_addr <= r_n;
          r_out_data <= w_result;
        end
        S_WRITE: begin
          if (r_n == C_LAST_NEURON) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_n     <= r_n + 1'b1;
            r_c     <= '0;
            r_state <= S_RUN;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.act_addr = r_c;
  assign bus.w_addr   = r_w_addr;
  assign bus.b_addr   = r_n;
  assign bus.out_wren = r_wren;
  assign bus.out_addr = r_out_addr;
  assign bus.out_data = r_out_data;
endmodule
`default_nettype wire
